// File: rtl/sqrt_lut_arbiter_pkg.sv
// sqrt_arb_pkg: shared widths, tag-width rule and tag pipe record for sqrt_lut_arbiter.
package sqrt_arb_pkg;
    localparam int DIN_WIDTH_DEF  = 17;
    localparam int DOUT_WIDTH_DEF = 16;
    localparam int MAX_CH         = 8;
    localparam int CH_W           = $clog2(MAX_CH);

    function automatic int tag_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic            valid;
        logic [CH_W-1:0] ch;
    } tag_t;
endpackage

// File: rtl/sqrt_lut_arbiter_if.sv
// sqrt_lut_arbiter_if: requester, response and shared-ROM signals of sqrt_lut_arbiter.
interface sqrt_lut_arbiter_if
    import sqrt_arb_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DIN_WIDTH  = DIN_WIDTH_DEF,
    parameter int DOUT_WIDTH = DOUT_WIDTH_DEF
);
    logic [N_CH*DIN_WIDTH-1:0]  req_din;
    logic [N_CH-1:0]            req_valid;
    logic [N_CH-1:0]            req_ready;
    logic [DIN_WIDTH-1:0]       lut_din;
    logic                       lut_din_valid;
    logic [DOUT_WIDTH-1:0]      lut_dout;
    logic                       lut_dout_valid;
    logic [N_CH*DOUT_WIDTH-1:0] resp_dout;
    logic [N_CH-1:0]            resp_valid;
    logic [N_CH-1:0]            resp_ready;
    logic                       tag_err;

    modport master (
        output req_din, req_valid, lut_dout, lut_dout_valid, resp_ready,
        input  req_ready, lut_din, lut_din_valid, resp_dout, resp_valid, tag_err
    );

    modport slave (
        input  req_din, req_valid, lut_dout, lut_dout_valid, resp_ready,
        output req_ready, lut_din, lut_din_valid, resp_dout, resp_valid, tag_err
    );
endinterface

// File: rtl/sqrt_lut_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first eligible channel after rr_ptr_i.
module rr_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int N_CH = 4,
    localparam int TAG_W = tag_w(N_CH)
) (
    input  logic [N_CH-1:0]  eligible_i,
    input  logic [TAG_W-1:0] rr_ptr_i,
    output logic [N_CH-1:0]  grant_o,
    output logic [TAG_W-1:0] grant_idx_o,
    output logic             grant_valid_o
);
    logic [TAG_W-1:0] idx;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        idx           = '0;
        for (int k = N_CH; k >= 1; k--) begin
            idx = TAG_W'((int'(rr_ptr_i) + k) % N_CH);
            if (eligible_i[idx]) begin
                grant_o       = '0;
                grant_o[idx]  = 1'b1;
                grant_idx_o   = idx;
                grant_valid_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sqrt_lut_arbiter.sv
// sqrt_lut_arbiter: round-robin sharing of one registered sqrt ROM among N_CH requesters.
// Defining SQRT_ARB_STATS_EN adds per-channel 32-bit grant counters on grant_cnt.
module sqrt_lut_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int DIN_WIDTH   = DIN_WIDTH_DEF,
    parameter int DOUT_WIDTH  = DOUT_WIDTH_DEF,
    parameter int LUT_LATENCY = 1
) (
    input logic clk,
    input logic rst,
    sqrt_lut_arbiter_if.slave bus
`ifdef SQRT_ARB_STATS_EN
    ,
    output logic [N_CH*32-1:0] grant_cnt
`endif
);
    localparam int TAG_W = tag_w(N_CH);

    logic [N_CH-1:0]            pending_q, pending_d, resp_valid_q, resp_valid_d;
    logic [N_CH-1:0]            eligible, grant, accept;
    logic [N_CH*DOUT_WIDTH-1:0] resp_dout_q, resp_dout_d;
    logic [DIN_WIDTH-1:0]       lut_din_q, lut_din_d;
    logic                       lut_din_valid_q, tag_err_q, tag_err_d;
    logic [TAG_W-1:0]           rr_ptr_q, rr_ptr_d, gidx;
    logic                       gv, hit, mism;
    logic [LUT_LATENCY-1:0]     quiet_q;
    tag_t                       tag_q [LUT_LATENCY+1];

    assign eligible = bus.req_valid & ~pending_q;
    assign accept   = resp_valid_q & bus.resp_ready;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .eligible_i    (eligible),
        .rr_ptr_i      (rr_ptr_q),
        .grant_o       (grant),
        .grant_idx_o   (gidx),
        .grant_valid_o (gv)
    );

    // Strobes from issues made just before reset may still land; quiet_q masks them.
    assign hit  = bus.lut_dout_valid & tag_q[LUT_LATENCY].valid;
    assign mism = (bus.lut_dout_valid != tag_q[LUT_LATENCY].valid) & ~quiet_q[0];

    always_comb begin
        pending_d    = (pending_q & ~accept) | grant;
        resp_valid_d = resp_valid_q & ~accept;
        resp_dout_d  = resp_dout_q;
        for (int i = 0; i < N_CH; i++) begin
            if (hit && tag_q[LUT_LATENCY].ch == CH_W'(i)) begin
                resp_valid_d[i]                        = 1'b1;
                resp_dout_d[i*DOUT_WIDTH +: DOUT_WIDTH] = bus.lut_dout;
            end
        end
        lut_din_d = gv ? bus.req_din[gidx*DIN_WIDTH +: DIN_WIDTH] : lut_din_q;
        rr_ptr_d  = gv ? gidx : rr_ptr_q;
        tag_err_d = tag_err_q | mism;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q       <= '0;
            resp_valid_q    <= '0;
            resp_dout_q     <= '0;
            lut_din_q       <= '0;
            lut_din_valid_q <= 1'b0;
            tag_err_q       <= 1'b0;
            rr_ptr_q        <= TAG_W'(N_CH - 1);
            quiet_q         <= '1;
            for (int k = 0; k <= LUT_LATENCY; k++) tag_q[k] <= '0;
        end else begin
            pending_q       <= pending_d;
            resp_valid_q    <= resp_valid_d;
            resp_dout_q     <= resp_dout_d;
            lut_din_q       <= lut_din_d;
            lut_din_valid_q <= gv;
            tag_err_q       <= tag_err_d;
            rr_ptr_q        <= rr_ptr_d;
            quiet_q         <= quiet_q >> 1;
            tag_q[0]        <= '{valid: gv, ch: CH_W'(gidx)};
            for (int k = 1; k <= LUT_LATENCY; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    assign bus.req_ready     = rst ? '0 : grant;
    assign bus.lut_din       = lut_din_q;
    assign bus.lut_din_valid = lut_din_valid_q;
    assign bus.resp_dout     = resp_dout_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.tag_err       = tag_err_q;

`ifdef SQRT_ARB_STATS_EN
    logic [N_CH*32-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++)
                if (grant[i]) cnt_q[i*32 +: 32] <= cnt_q[i*32 +: 32] + 32'd1;
        end
    end

    assign grant_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_sqrt_lut_arbiter.sv
// tb_sqrt_lut_arbiter: vector table, directed corner sequences and a randomized run against a
// transaction-level model of sqrt_lut_arbiter with a registered sqrt ROM in the bench.
module tb_sqrt_lut_arbiter;
    import sqrt_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 17;
    localparam int OW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sqrt_lut_arbiter_if #(.N_CH(N), .DIN_WIDTH(DW), .DOUT_WIDTH(OW)) bus ();

    logic          rom_v  = 1'b0;
    logic          inject = 1'b0;
    logic [OW-1:0] rom_d  = '0;

`ifdef SQRT_ARB_STATS_EN
    logic [N*32-1:0] grant_cnt;
`endif

    sqrt_lut_arbiter #(.N_CH(N), .DIN_WIDTH(DW), .DOUT_WIDTH(OW), .LUT_LATENCY(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SQRT_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    // floor(sqrt(x) * 64) == floor(sqrt(x * 4096))
    function automatic logic [15:0] isqrt(input logic [16:0] x);
        longint v;
        longint r;
        longint t;
        v = longint'(x) << 12;
        r = 0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= v) r = t;
        end
        return 16'(r);
    endfunction

    always @(posedge clk) begin
        rom_v <= bus.lut_din_valid;
        rom_d <= isqrt(bus.lut_din);
    end
    assign bus.lut_dout_valid = rom_v | inject;
    assign bus.lut_dout       = rom_d;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_din(input int ch, input logic [DW-1:0] d);
        bus.req_din[ch*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.resp_ready = '0;
        inject         = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        int          ch;
        logic [16:0] din;
        logic [15:0] exp;
    } vec_t;

    vec_t        vt [8];
    logic [15:0] rot_exp [N];
    logic [N-1:0] m;
    int          gcnt [N];
    bit          busy [N];
    int          arrive [N];
    logic [15:0] val [N];
    int          last;

    initial begin
        bus.req_din    = '0;
        bus.req_valid  = '0;
        bus.resp_ready = '0;

        vt[0] = '{0, 17'd16,     16'h0100};
        vt[1] = '{1, 17'd100,    16'h0280};
        vt[2] = '{2, 17'd0,      16'h0000};
        vt[3] = '{3, 17'd131071, 16'h5A82};
        vt[4] = '{1, 17'd1,      16'h0040};
        vt[5] = '{2, 17'd4,      16'h0080};
        vt[6] = '{0, 17'd2,      16'h005A};
        vt[7] = '{3, 17'd65536,  16'h4000};

        do_reset();
        #1;
        chk("rst_resp_valid", 64'(bus.resp_valid), 0);
        chk("rst_resp_dout", 64'(bus.resp_dout), 0);
        chk("rst_lut_din", 64'(bus.lut_din), 0);
        chk("rst_lut_din_valid", 64'(bus.lut_din_valid), 0);
        chk("rst_tag_err", 64'(bus.tag_err), 0);
        chk("rst_req_ready", 64'(bus.req_ready), 0);
        @(negedge clk);

        // Single-channel transactions: latency and routing per table entry
        for (int k = 0; k < 8; k++) begin
            m = N'(1) << vt[k].ch;
            set_din(vt[k].ch, vt[k].din);
            bus.req_valid  = m;
            bus.resp_ready = '0;
            #1 chk("tbl_ready", 64'(bus.req_ready), 64'(m));
            @(negedge clk);
            bus.req_valid = '0;
            #1 chk("tbl_lut_valid", 64'(bus.lut_din_valid), 1);
            chk("tbl_lut_din", 64'(bus.lut_din), 64'(vt[k].din));
            @(negedge clk);
            #1 chk("tbl_lut_valid_off", 64'(bus.lut_din_valid), 0);
            chk("tbl_resp_early", 64'(bus.resp_valid), 0);
            @(negedge clk);
            #1 chk("tbl_resp_valid", 64'(bus.resp_valid), 64'(m));
            chk("tbl_resp_dout", 64'(bus.resp_dout[vt[k].ch*OW +: OW]), 64'(vt[k].exp));
            bus.resp_ready = m;
            @(negedge clk);
            #1 chk("tbl_resp_clear", 64'(bus.resp_valid), 0);
            bus.resp_ready = '0;
            @(negedge clk);
        end

        // Full rotation with all channels busy
        do_reset();
        for (int i = 0; i < N; i++) begin
            set_din(i, vt[i == 2 ? 0 : (i == 0 ? 2 : i)].din);
            rot_exp[i] = vt[i == 2 ? 0 : (i == 0 ? 2 : i)].exp;
        end
        bus.req_valid  = '1;
        bus.resp_ready = '1;
        for (int c = 0; c < 16; c++) begin
            #1 chk("rot_grant", 64'(bus.req_ready), 64'(N'(1) << (c % N)));
            for (int i = 0; i < N; i++)
                if (bus.resp_valid[i]) chk("rot_dout", 64'(bus.resp_dout[i*OW +: OW]), 64'(rot_exp[i]));
            @(negedge clk);
        end

        // ch2 response stalled: one issue only, others keep rotating
        do_reset();
        bus.req_valid  = '1;
        bus.resp_ready = 4'b1011;
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            for (int i = 0; i < N; i++) if (bus.req_ready[i]) gcnt[i]++;
            @(negedge clk);
        end
        chk("stall_ch2_cnt", 64'(gcnt[2]), 1);
        chk("stall_ch0_cnt", 64'(gcnt[0]), 5);
        chk("stall_ch1_cnt", 64'(gcnt[1]), 5);
        chk("stall_ch3_cnt", 64'(gcnt[3]), 5);
        bus.req_valid  = 4'b0100;
        bus.resp_ready = 4'b0100;
        #1 chk("stall_held", 64'(bus.resp_valid[2]), 1);
        chk("stall_no_grant", 64'(bus.req_ready), 0);
        @(negedge clk);
        #1 chk("stall_regrant", 64'(bus.req_ready), 64'(4'b0100));
        chk("stall_resp_clear", 64'(bus.resp_valid[2]), 0);
        @(negedge clk);

        // Reset with three requests in flight
        do_reset();
        bus.req_valid  = '1;
        bus.resp_ready = '1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1 chk("midrst_ready", 64'(bus.req_ready), 0);
        @(negedge clk);
        rst           = 1'b0;
        bus.req_valid = '0;
        #1 chk("midrst_resp_valid", 64'(bus.resp_valid), 0);
        chk("midrst_lut_valid", 64'(bus.lut_din_valid), 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 chk("midrst_quiet_resp", 64'(bus.resp_valid), 0);
            chk("midrst_tag_err", 64'(bus.tag_err), 0);
        end
        @(negedge clk);
        bus.req_valid = '1;
        #1 chk("midrst_first_grant", 64'(bus.req_ready), 64'(4'b0001));
        @(negedge clk);

        // Spurious ROM strobe with empty tag pipe
        do_reset();
        repeat (3) @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1 chk("spur_tag_err", 64'(bus.tag_err), 1);
            chk("spur_resp_valid", 64'(bus.resp_valid), 0);
            @(negedge clk);
        end
        do_reset();
        #1 chk("spur_cleared", 64'(bus.tag_err), 0);
        @(negedge clk);

        // Randomized traffic against a transaction-level model
        do_reset();
        last = N - 1;
        for (int i = 0; i < N; i++) begin
            busy[i]   = 1'b0;
            arrive[i] = 0;
            val[i]    = '0;
        end
        for (int c = 0; c < 2000; c++) begin
            logic [N-1:0] erv;
            logic [N-1:0] eg;
            int           g;
            for (int i = 0; i < N; i++) erv[i] = busy[i] && c >= arrive[i];
            chk("rnd_resp_valid", 64'(bus.resp_valid), 64'(erv));
            for (int i = 0; i < N; i++)
                if (erv[i]) chk("rnd_resp_dout", 64'(bus.resp_dout[i*OW +: OW]), 64'(val[i]));
            bus.req_valid  = N'($urandom);
            bus.resp_ready = N'($urandom);
            for (int i = 0; i < N; i++) set_din(i, DW'($urandom));
            #1;
            g  = -1;
            eg = '0;
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (last + k) % N;
                if (g < 0 && bus.req_valid[idx] && !busy[idx]) g = idx;
            end
            if (g >= 0) eg = N'(1) << g;
            chk("rnd_grant", 64'(bus.req_ready), 64'(eg));
            if (c % 50 == 0) chk("rnd_tag_err", 64'(bus.tag_err), 0);
            for (int i = 0; i < N; i++) if (erv[i] && bus.resp_ready[i]) busy[i] = 1'b0;
            if (g >= 0) begin
                busy[g]   = 1'b1;
                arrive[g] = c + 3;
                val[g]    = isqrt(bus.req_din[g*DW +: DW]);
                last      = g;
            end
            @(negedge clk);
        end

`ifdef SQRT_ARB_STATS_EN
        do_reset();
        bus.req_valid  = 4'b0010;
        bus.resp_ready = 4'b0010;
        repeat (40) @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        #1 chk("stats_ch1", 64'(grant_cnt[32 +: 32]), 10);
        chk("stats_ch0", 64'(grant_cnt[0 +: 32]), 0);
        chk("stats_ch2", 64'(grant_cnt[64 +: 32]), 0);
        chk("stats_ch3", 64'(grant_cnt[96 +: 32]), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
